// File: rtl/and4_sweep_checker.sv
// Exhaustive 16-vector sweep checker for a 4-input AND: applies each vector, samples the response, counts mismatches.
// Optional macro FIRST_FAIL_CAPTURE_EN records the first mismatching vector of each sweep.
module and4_sweep_checker #(
  parameter int unsigned SETTLE_CYCLES = 19
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic [3:0] dut_in,
  input  logic       dut_out,
  output logic       busy,
  output logic       done,
  output logic [4:0] err_cnt,
  output logic       fail,
  output logic [3:0] first_fail_vec,
  output logic       first_fail_vld
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] settle_cnt;
  logic       accept;
  logic       mismatch;
  logic       last_vec;

  assign accept   = (state == IDLE) && start;
  assign mismatch = (state == SAMPLE) && (dut_out != (&dut_in));
  assign last_vec = (dut_in == 4'hF);
  assign fail     = (err_cnt != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = SETTLE;
      SETTLE:  if (settle_cnt == SETTLE_LAST) state_nxt = SAMPLE;
      SAMPLE:  state_nxt = last_vec ? DONE : SETTLE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state)
      SETTLE,
      SAMPLE:  busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dut_in     <= '0;
      settle_cnt <= '0;
      err_cnt    <= '0;
    end else begin
      if (accept) begin
        dut_in     <= '0;
        settle_cnt <= '0;
        err_cnt    <= '0;
      end
      if (state == SETTLE) settle_cnt <= settle_cnt + 8'd1;
      if (mismatch) err_cnt <= err_cnt + 5'd1;
      if ((state == SAMPLE) && !last_vec) begin
        dut_in     <= dut_in + 4'd1;
        settle_cnt <= '0;
      end
    end
  end

`ifdef FIRST_FAIL_CAPTURE_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      first_fail_vec <= '0;
      first_fail_vld <= 1'b0;
    end else if (accept) begin
      first_fail_vld <= 1'b0;
    end else if (mismatch && !first_fail_vld) begin
      first_fail_vec <= dut_in;
      first_fail_vld <= 1'b1;
    end
  end
`else
  assign first_fail_vec = '0;
  assign first_fail_vld = 1'b0;
`endif

endmodule
